// File: rtl/fft_peak_finder.sv
// fft_peak_finder
//   Scans the positive-frequency half of a completed FFT spectrum (bins
//   1 .. N/2-1), computes re^2 + im^2 for every bin and publishes the index
//   and magnitude of the strongest bin with a one-cycle valid pulse.
//
// Ports
//   clk         system clock, rising edge
//   reset       synchronous, active-low reset
//   done        FFT completion level; a rising edge in IDLE starts a scan,
//               a falling edge during SCAN/FLUSH aborts it
//   re_in/im_in signed spectrum sample for the address of the previous cycle
//   rd_adr      spectrum read address (0 outside SCAN)
//   busy        high while scanning or draining the pipeline
//   peak_valid  one-cycle pulse when peak_bin/peak_mag are updated
//   peak_bin    index of the strongest bin (lowest index wins ties)
//   peak_mag    unsigned re^2 + im^2 of that bin
module fft_peak_finder #(
  parameter int bit_width = 16,
  parameter int N         = 512,
  parameter int M         = 9
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        done,
  input  logic signed [bit_width-1:0] re_in,
  input  logic signed [bit_width-1:0] im_in,
  output logic [M-1:0]                rd_adr,
  output logic                        busy,
  output logic                        peak_valid,
  output logic [M-1:0]                peak_bin,
  output logic [2*bit_width-1:0]      peak_mag
);

  localparam int MW = 2 * bit_width;
  localparam logic [M-1:0] LAST_ADR = M'(N / 2 - 1);

  typedef enum logic [1:0] {IDLE, SCAN, FLUSH, REPORT} state_t;

  state_t          state_reg;
  logic            done_q_reg;
  logic            flush_cnt_reg;

  // Stage 1: address that the RAM is returning data for in this cycle.
  logic [M-1:0]    adr_d1_reg;
  logic            v_d1_reg;
  // Stage 2: registered magnitude and its bin.
  logic [M-1:0]    bin_d2_reg;
  logic [MW-1:0]   mag_d2_reg;
  logic            v_d2_reg;
  // Running maximum.
  logic [M-1:0]    max_bin_reg;
  logic [MW-1:0]   max_mag_reg;

  logic signed [MW-1:0] re_ext, im_ext, re_sq, im_sq;
  logic [MW-1:0]        mag_now;
  logic                 upd;
  logic [M-1:0]         max_bin_next;
  logic [MW-1:0]        max_mag_next;

  // Both squares are non-negative and at most 2^(2w-2) each, so their
  // unsigned sum fits in 2w bits without overflow.
  assign re_ext  = {{bit_width{re_in[bit_width-1]}}, re_in};
  assign im_ext  = {{bit_width{im_in[bit_width-1]}}, im_in};
  assign re_sq   = re_ext * re_ext;
  assign im_sq   = im_ext * im_ext;
  assign mag_now = $unsigned(re_sq) + $unsigned(im_sq);

  // Strictly-greater compare keeps the earliest (lowest) bin on ties.
  // Gating on SCAN/FLUSH keeps stale pipeline contents from an aborted run
  // out of a freshly started one.
  assign upd = v_d2_reg && ((state_reg == SCAN) || (state_reg == FLUSH)) &&
               (mag_d2_reg > max_mag_reg);
  assign max_bin_next = upd ? bin_d2_reg : max_bin_reg;
  assign max_mag_next = upd ? mag_d2_reg : max_mag_reg;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg     <= IDLE;
      done_q_reg    <= 1'b0;
      flush_cnt_reg <= 1'b0;
      adr_d1_reg    <= '0;
      v_d1_reg      <= 1'b0;
      bin_d2_reg    <= '0;
      mag_d2_reg    <= '0;
      v_d2_reg      <= 1'b0;
      max_bin_reg   <= '0;
      max_mag_reg   <= '0;
      rd_adr        <= '0;
      busy          <= 1'b0;
      peak_valid    <= 1'b0;
      peak_bin      <= '0;
      peak_mag      <= '0;
    end else begin
      done_q_reg  <= done;
      adr_d1_reg  <= rd_adr;
      v_d1_reg    <= (state_reg == SCAN);
      bin_d2_reg  <= adr_d1_reg;
      mag_d2_reg  <= mag_now;
      v_d2_reg    <= v_d1_reg;
      max_bin_reg <= max_bin_next;
      max_mag_reg <= max_mag_next;
      peak_valid  <= 1'b0;

      case (state_reg)
        IDLE: begin
          if (done && !done_q_reg) begin
            state_reg   <= SCAN;
            rd_adr      <= M'(1);  // bin 0 (DC) is skipped
            busy        <= 1'b1;
            max_bin_reg <= '0;
            max_mag_reg <= '0;
          end
        end
        SCAN: begin
          if (!done) begin
            state_reg <= IDLE;
            rd_adr    <= '0;
            busy      <= 1'b0;
            v_d1_reg  <= 1'b0;
            v_d2_reg  <= 1'b0;
          end else if (rd_adr == LAST_ADR) begin
            state_reg     <= FLUSH;
            rd_adr        <= '0;
            flush_cnt_reg <= 1'b0;
          end else begin
            rd_adr <= rd_adr + 1'b1;
          end
        end
        FLUSH: begin
          if (!done) begin
            state_reg <= IDLE;
            busy      <= 1'b0;
            v_d1_reg  <= 1'b0;
            v_d2_reg  <= 1'b0;
          end else if (flush_cnt_reg) begin
            // The last bin's compare lands on this same edge, so publish
            // the post-compare value rather than the registered max.
            state_reg  <= REPORT;
            busy       <= 1'b0;
            peak_valid <= 1'b1;
            peak_bin   <= max_bin_next;
            peak_mag   <= max_mag_next;
          end else begin
            flush_cnt_reg <= 1'b1;
          end
        end
        REPORT: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fft_peak_finder.sv
module tb_fft_peak_finder;

  localparam int BW = 16;
  localparam int NN = 512;
  localparam int MM = 9;

  logic                 clk;
  logic                 reset;
  logic                 done;
  logic signed [BW-1:0] re_in;
  logic signed [BW-1:0] im_in;
  logic [MM-1:0]        rd_adr;
  logic                 busy;
  logic                 peak_valid;
  logic [MM-1:0]        peak_bin;
  logic [2*BW-1:0]      peak_mag;

  fft_peak_finder #(.bit_width(BW), .N(NN), .M(MM)) dut (
    .clk        (clk),
    .reset      (reset),
    .done       (done),
    .re_in      (re_in),
    .im_in      (im_in),
    .rd_adr     (rd_adr),
    .busy       (busy),
    .peak_valid (peak_valid),
    .peak_bin   (peak_bin),
    .peak_mag   (peak_mag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Spectrum RAM model with a registered read port.
  logic signed [BW-1:0] re_mem [0:NN-1];
  logic signed [BW-1:0] im_mem [0:NN-1];
  always @(posedge clk) begin
    re_in <= re_mem[rd_adr];
    im_in <= im_mem[rd_adr];
  end

  typedef struct {
    int     bin_a;
    int     re_a;
    int     im_a;
    int     bin_b;   // -1: unused
    int     re_b;
    int     im_b;
    bit     pollute; // put large values in bins 0 and 300
    int     exp_bin;
    longint exp_mag;
  } vec_t;

  typedef struct {
    int     bin;
    longint mag;
  } exp_t;

  vec_t vecs [0:4];
  exp_t sb [$];

  int checks = 0;
  int errors = 0;
  int pulses = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Advance one cycle and sample #1 after the edge; every peak_valid pulse
  // is matched against the scoreboard here.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    if (peak_valid) begin
      pulses++;
      if (sb.size() == 0) begin
        check("spurious_peak_valid", longint'(peak_valid), 0);
      end else begin
        e = sb.pop_front();
        check("peak_bin", longint'(peak_bin), longint'(e.bin));
        check("peak_mag", longint'(peak_mag), e.mag);
        $display("result: bin %0d mag %0d (expected %0d / %0d)",
                 peak_bin, peak_mag, e.bin, e.mag);
      end
    end
  endtask

  task automatic load(input int idx);
    for (int i = 0; i < NN; i++) begin
      re_mem[i] = '0;
      im_mem[i] = '0;
    end
    if (vecs[idx].bin_a >= 0) begin
      re_mem[vecs[idx].bin_a] = 16'(vecs[idx].re_a);
      im_mem[vecs[idx].bin_a] = 16'(vecs[idx].im_a);
    end
    if (vecs[idx].bin_b >= 0) begin
      re_mem[vecs[idx].bin_b] = 16'(vecs[idx].re_b);
      im_mem[vecs[idx].bin_b] = 16'(vecs[idx].im_b);
    end
    if (vecs[idx].pollute) begin
      re_mem[0]   = 16'sd20000;
      im_mem[0]   = 16'sd20000;
      re_mem[300] = 16'sd20000;
      im_mem[300] = 16'sd20000;
    end
  endtask

  // Full run: raise done, follow the address/busy sequence and require one
  // pulse exactly N/2+2 cycles after the sampling edge.
  task automatic run_case(input int idx, input bit keep_done);
    exp_t e;
    int   seq_err;
    int   pulse_cyc;
    int   exp_adr;
    load(idx);
    e.bin = vecs[idx].exp_bin;
    e.mag = vecs[idx].exp_mag;
    sb.push_back(e);
    pulses    = 0;
    seq_err   = 0;
    pulse_cyc = -1;
    done      = 1'b1;
    for (int c = 1; c <= 262; c++) begin
      tick();
      exp_adr = (c <= 255) ? c : 0;
      if (int'(rd_adr) != exp_adr) seq_err++;
      if (busy != (c <= 257)) seq_err++;
      if (peak_valid) pulse_cyc = c;
    end
    check("rd_adr_busy_seq", seq_err, 0);
    check("valid_pulses", pulses, 1);
    check("valid_latency", pulse_cyc, 258);
    check("scoreboard_drained", sb.size(), 0);
    sb.delete();
    if (!keep_done) begin
      done = 1'b0;
      tick();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    vecs[0] = '{37,  1000,   -500,  -1,  0,    0,    1'b0, 37,  64'd1250000};
    vecs[1] = '{40,  300,    400,   80,  300,  400,  1'b1, 40,  64'd250000};
    vecs[2] = '{255, -32768, -32768, -1, 0,    0,    1'b0, 255, 64'h8000_0000};
    vecs[3] = '{-1,  0,      0,     -1,  0,    0,    1'b0, 0,   64'd0};
    vecs[4] = '{10,  100,    0,     200, 0,    -101, 1'b0, 200, 64'd10201};

    load(3);
    reset = 1'b0;
    done  = 1'b0;
    repeat (3) tick();
    check("reset_rd_adr", longint'(rd_adr), 0);
    check("reset_busy", longint'(busy), 0);
    check("reset_peak_valid", longint'(peak_valid), 0);
    check("reset_peak_bin", longint'(peak_bin), 0);
    check("reset_peak_mag", longint'(peak_mag), 0);
    reset = 1'b1;
    repeat (2) tick();

    for (int v = 0; v < 5; v++) begin
      $display("vector %0d: expect bin %0d mag %0d", v, vecs[v].exp_bin, vecs[v].exp_mag);
      run_case(v, 1'b0);
      repeat (3) tick();
    end

    // done held high across the return to IDLE must not start a new run.
    run_case(0, 1'b1);
    pulses = 0;
    bad    = 0;
    for (int c = 0; c < 300; c++) begin
      tick();
      if (busy) bad++;
    end
    check("retrigger_busy", bad, 0);
    check("retrigger_pulses", pulses, 0);
    $display("retrigger hold: busy cycles %0d pulses %0d", bad, pulses);
    done = 1'b0;
    repeat (3) tick();

    // Abort in cycle k+100 with a different spectrum loaded.
    load(0);
    re_mem[50] = 16'sd2000;
    pulses = 0;
    done   = 1'b1;
    for (int c = 1; c <= 100; c++) tick();
    done = 1'b0;
    tick();
    check("abort_busy", longint'(busy), 0);
    check("abort_rd_adr", longint'(rd_adr), 0);
    for (int c = 0; c < 300; c++) tick();
    check("abort_pulses", pulses, 0);
    check("abort_peak_bin", longint'(peak_bin), 37);
    check("abort_peak_mag", longint'(peak_mag), 1250000);
    $display("abort: bin %0d mag %0d pulses %0d", peak_bin, peak_mag, pulses);

    // Reset asserted in cycle k+120.
    load(0);
    done = 1'b1;
    for (int c = 1; c <= 120; c++) tick();
    reset = 1'b0;
    done  = 1'b0;
    tick();
    check("midreset_rd_adr", longint'(rd_adr), 0);
    check("midreset_busy", longint'(busy), 0);
    check("midreset_peak_valid", longint'(peak_valid), 0);
    check("midreset_peak_bin", longint'(peak_bin), 0);
    check("midreset_peak_mag", longint'(peak_mag), 0);
    $display("mid-scan reset: rd_adr %0d busy %0d bin %0d mag %0d",
             rd_adr, busy, peak_bin, peak_mag);
    repeat (3) tick();
    reset = 1'b1;
    repeat (2) tick();
    run_case(1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
